// File: rtl/icache_fetch.sv
// Direct-mapped instruction cache sitting between the datapath fetch port and
// a slower instruction memory. Hits are answered combinationally in IDLE; a
// miss fills the whole line one word per beat, then the lookup re-evaluates.
//
// Memory handshake: while mem_read is high, mem_address is held stable until
// a cycle in which mem_valid is high. That cycle's rising edge consumes
// mem_data for mem_address. mem_valid has no meaning while mem_read is low.
// CPU handshake: readyC high means dataC belongs to addressC this cycle.
// While readyC is low the CPU keeps stalling.
module icache_fetch #(
   parameter int WORD_SIZE  = 16,
   parameter int LINE_WORDS = 4,
   parameter int NUM_LINES  = 4
) (
   input  logic                 Clk,
   input  logic                 Reset,
   input  logic                 readC,
   input  logic [WORD_SIZE-1:0] addressC,
   output logic [WORD_SIZE-1:0] dataC,
   output logic                 readyC,
   input  logic                 invalidate,
   output logic                 mem_read,
   output logic [WORD_SIZE-1:0] mem_address,
   input  logic [WORD_SIZE-1:0] mem_data,
   input  logic                 mem_valid,
   output logic [WORD_SIZE-1:0] num_hit,
   output logic [WORD_SIZE-1:0] num_miss,
   output logic                 fsm_state
);

   localparam int OFS = $clog2(LINE_WORDS);
   localparam int IDX = $clog2(NUM_LINES);
   localparam int TAG = WORD_SIZE - IDX - OFS;

   typedef enum logic {IDLE = 1'b0, FILL = 1'b1} state_t;

   state_t state;
   state_t state_next;

   logic [TAG-1:0]         tag_arr  [NUM_LINES];
   logic [WORD_SIZE-1:0]   data_arr [NUM_LINES*LINE_WORDS];
   logic [NUM_LINES-1:0]   valid;
   logic                   pend_inv;
   logic [OFS-1:0]         beat;
   logic [WORD_SIZE-OFS-1:0] fill_base;

   logic [TAG-1:0] req_tag;
   logic [IDX-1:0] req_idx;
   logic [OFS-1:0] req_ofs;
   logic [TAG-1:0] fill_tag;
   logic [IDX-1:0] fill_idx;
   logic           lookup_hit;
   logic           hit;
   logic           miss;
   logic           fill_beat;
   logic           fill_done;

   assign req_tag  = addressC[WORD_SIZE-1:IDX+OFS];
   assign req_idx  = addressC[IDX+OFS-1:OFS];
   assign req_ofs  = addressC[OFS-1:0];
   assign fill_tag = fill_base[WORD_SIZE-OFS-1:IDX];
   assign fill_idx = fill_base[IDX-1:0];

   assign lookup_hit = readC & valid[req_idx] & (tag_arr[req_idx] == req_tag);
   assign hit        = (state == IDLE) & lookup_hit;
   assign miss       = (state == IDLE) & readC & ~lookup_hit;
   assign fill_beat  = (state == FILL) & mem_valid;
   assign fill_done  = fill_beat & (beat == OFS'(LINE_WORDS - 1));

   // State register; reset aborts any fill at once so mem_read drops without a clock.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) state <= IDLE;
      else       state <= state_next;
   end

   // Next-state: a miss starts a fill; the last accepted beat returns to lookup.
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (miss)      state_next = FILL;
         FILL:    if (fill_done) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Outputs: hit data is combinational; fill requests come straight from state.
   always_comb begin
      readyC      = hit;
      dataC       = hit ? data_arr[{req_idx, req_ofs}] : '0;
      mem_read    = (state == FILL);
      mem_address = (state == FILL) ? {fill_base, beat} : '0;
      fsm_state   = (state == FILL);
   end

   // Control state: valid bits, deferred invalidate, beat counter, perf counters.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         valid     <= '0;
         pend_inv  <= 1'b0;
         beat      <= '0;
         fill_base <= '0;
         num_hit   <= '0;
         num_miss  <= '0;
      end else begin
         if (hit) num_hit <= num_hit + WORD_SIZE'(1);
         if (miss) begin
            fill_base <= addressC[WORD_SIZE-1:OFS];
            beat      <= '0;
            num_miss  <= num_miss + WORD_SIZE'(1);
         end
         if (fill_beat) beat <= beat + OFS'(1);
         if ((state == IDLE) && invalidate) valid <= '0;
         if ((state == FILL) && invalidate) pend_inv <= 1'b1;
         // An invalidate seen at any point of the fill kills the new line too.
         if (fill_done) begin
            if (pend_inv | invalidate) begin
               valid    <= '0;
               pend_inv <= 1'b0;
            end else begin
               valid[fill_idx] <= 1'b1;
            end
         end
      end
   end

   // Tag and data storage; contents are meaningless until the valid bit is set.
   always_ff @(posedge Clk) begin
      if (fill_beat) data_arr[{fill_idx, beat}] <= mem_data;
      if (fill_done) tag_arr[fill_idx] <= fill_tag;
   end

endmodule

// File: tb/tb_icache_fetch.sv
// Directed bench for icache_fetch. Fetch data expectations and the expected
// order of memory fill addresses are queued when each fetch is issued; the
// data monitor and the memory model pop and compare independently.
module tb_icache_fetch;

   localparam int W = 16;

   logic         Clk;
   logic         Reset;
   logic         readC;
   logic [W-1:0] addressC;
   logic [W-1:0] dataC;
   logic         readyC;
   logic         invalidate;
   logic         mem_read;
   logic [W-1:0] mem_address;
   logic [W-1:0] mem_data;
   logic         mem_valid;
   logic [W-1:0] num_hit;
   logic [W-1:0] num_miss;
   logic         fsm_state;

   int total = 0;
   int bad   = 0;

   logic [W-1:0] exp_q[$];
   logic [W-1:0] addr_q[$];

   int exp_hit  = 0;
   int exp_miss = 0;

   icache_fetch #(.WORD_SIZE(16), .LINE_WORDS(4), .NUM_LINES(4)) dut (
      .Clk         (Clk),
      .Reset       (Reset),
      .readC       (readC),
      .addressC    (addressC),
      .dataC       (dataC),
      .readyC      (readyC),
      .invalidate  (invalidate),
      .mem_read    (mem_read),
      .mem_address (mem_address),
      .mem_data    (mem_data),
      .mem_valid   (mem_valid),
      .num_hit     (num_hit),
      .num_miss    (num_miss),
      .fsm_state   (fsm_state)
   );

   // Clock
   initial begin
      Clk = 1'b0;
      forever #5 Clk = ~Clk;
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, got, want);
      end
   endtask

   // Data monitor: every readyC cycle must match the oldest queued fetch.
   initial begin
      forever begin
         @(negedge Clk);
         if (readyC === 1'b1) begin
            total++;
            if (exp_q.size() == 0) begin
               bad++;
               $display("FAIL dataC: unexpected readyC with dataC=%0h", dataC);
            end else begin
               logic [W-1:0] want;
               want = exp_q.pop_front();
               if (dataC !== want) begin
                  bad++;
                  $display("FAIL dataC: got %0h want %0h", dataC, want);
               end
            end
         end
      end
   end

   // Memory model: data = address + 0x1000, mem_valid two cycles after each new address.
   initial begin
      int cnt;
      cnt       = 0;
      mem_valid = 1'b0;
      mem_data  = '0;
      forever begin
         @(negedge Clk);
         if (Reset || !mem_read) begin
            mem_valid = 1'b0;
            cnt       = 0;
         end else if (mem_valid) begin
            mem_valid = 1'b0;
            cnt       = 1;
         end else begin
            cnt++;
            if (cnt >= 2) begin
               mem_valid = 1'b1;
               mem_data  = mem_address + 16'h1000;
               total++;
               if (addr_q.size() == 0) begin
                  bad++;
                  $display("FAIL mem_address: unexpected fill beat at %0h", mem_address);
               end else begin
                  logic [W-1:0] want;
                  want = addr_q.pop_front();
                  if (mem_address !== want) begin
                     bad++;
                     $display("FAIL mem_address: got %0h want %0h", mem_address, want);
                  end
               end
            end
         end
      end
   end

   task automatic push_line(input logic [W-1:0] base);
      for (int i = 0; i < 4; i++) addr_q.push_back(base + W'(i));
   endtask

   // Driver: hold a fetch until readyC, optionally pulsing invalidate or
   // redirecting the PC after a given number of clock edges.
   task automatic fetch(input logic [W-1:0] addr, input logic [W-1:0] exp_data,
                        input int exp_cyc, input int inv_cyc,
                        input logic [W-1:0] flush_addr, input int flush_cyc);
      int cyc;
      bit done;
      exp_q.push_back(exp_data);
      readC      = 1'b1;
      addressC   = addr;
      invalidate = (inv_cyc == 0);
      cyc        = 0;
      done       = 1'b0;
      while (!done) begin
         @(negedge Clk);
         if (readyC === 1'b1) begin
            done = 1'b1;
         end else begin
            @(posedge Clk);
            #1;
            cyc++;
            invalidate = (cyc == inv_cyc);
            if (cyc == flush_cyc) addressC = flush_addr;
            if (cyc > 60) begin
               $display("FAIL fetch_timeout: addr %0h no readyC after %0d cycles", addr, cyc);
               done = 1'b1;
            end
         end
      end
      check("fetch_cycles", cyc, exp_cyc);
      @(posedge Clk);
      #1;
      readC      = 1'b0;
      invalidate = 1'b0;
   endtask

   task automatic check_counters(input string tag);
      check({tag, "_num_hit"},  num_hit,  exp_hit);
      check({tag, "_num_miss"}, num_miss, exp_miss);
      check({tag, "_mem_read"}, mem_read, 1'b0);
   endtask

   // Stimulus
   initial begin
      Reset      = 1'b1;
      readC      = 1'b0;
      addressC   = '0;
      invalidate = 1'b0;
      repeat (2) @(posedge Clk);
      #1;
      check("rst_dataC", dataC, 16'h0);
      check("rst_readyC", readyC, 1'b0);
      check("rst_mem_read", mem_read, 1'b0);
      check("rst_mem_address", mem_address, 16'h0);
      check("rst_num_hit", num_hit, 16'h0);
      check("rst_num_miss", num_miss, 16'h0);
      check("rst_state", fsm_state, 1'b0);
      Reset = 1'b0;
      @(posedge Clk);
      #1;

      // Cold miss: 1 + 4 beats of 2 cycles
      push_line(16'h0004);
      fetch(16'h0005, 16'h1005, 9, -1, '0, -1);
      exp_miss = 1; exp_hit = 1;
      check_counters("cold");

      // Sequential hits, one per cycle
      for (int i = 4; i < 8; i++) fetch(W'(i), W'(16'h1000 + i), 0, -1, '0, -1);
      exp_hit = 5;
      check_counters("seq");

      // Conflict on index 1
      push_line(16'h0014);
      fetch(16'h0014, 16'h1014, 9, -1, '0, -1);
      push_line(16'h0004);
      fetch(16'h0004, 16'h1004, 9, -1, '0, -1);
      exp_hit = 7; exp_miss = 3;
      check_counters("conflict");

      // Invalidate in IDLE alongside a hit: hit still reported and counted
      fetch(16'h0005, 16'h1005, 0, 0, '0, -1);
      exp_hit = 8;
      check_counters("inv_hit");
      push_line(16'h0004);
      fetch(16'h0005, 16'h1005, 9, -1, '0, -1);
      exp_hit = 9; exp_miss = 4;
      check_counters("inv_remiss");

      // Invalidate pulse with no fetch; a valid address must not report ready
      readC = 1'b0; addressC = 16'h0005; invalidate = 1'b1;
      @(negedge Clk);
      check("idle_readyC", readyC, 1'b0);
      check("idle_dataC", dataC, 16'h0);
      @(posedge Clk);
      #1;
      invalidate = 1'b0;
      push_line(16'h0014);
      fetch(16'h0014, 16'h1014, 9, -1, '0, -1);
      exp_hit = 10; exp_miss = 5;
      check_counters("inv_idle");

      // Invalidate during a fill: line is dropped, fetch misses again
      push_line(16'h0020);
      push_line(16'h0020);
      fetch(16'h0020, 16'h1020, 18, 3, '0, -1);
      exp_hit = 11; exp_miss = 7;
      check_counters("inv_fill");

      // Branch flush during beat-1 wait: 0x30 line completes, then 0x40 fills
      push_line(16'h0030);
      push_line(16'h0040);
      fetch(16'h0030, 16'h1040, 18, -1, 16'h0040, 3);
      exp_hit = 12; exp_miss = 9;
      check_counters("flush");

      // Reset mid-fill during the beat-2 wait
      push_line(16'h0030);
      void'(addr_q.pop_back());
      void'(addr_q.pop_back());
      readC = 1'b1; addressC = 16'h0030;
      repeat (5) @(posedge Clk);
      #3;
      Reset = 1'b1;
      #1;
      check("rstfill_mem_read", mem_read, 1'b0);
      check("rstfill_readyC", readyC, 1'b0);
      check("rstfill_num_miss", num_miss, 16'h0);
      check("rstfill_addr_q_drained", addr_q.size(), 0);
      readC = 1'b0;
      @(posedge Clk);
      @(posedge Clk);
      #1;
      Reset = 1'b0;
      exp_hit = 0; exp_miss = 0;
      push_line(16'h0030);
      fetch(16'h0030, 16'h1030, 9, -1, '0, -1);
      exp_hit = 1; exp_miss = 1;
      check_counters("after_rst");

      repeat (3) @(posedge Clk);
      check("exp_q_empty", exp_q.size(), 0);
      check("addr_q_empty", addr_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Watchdog
   initial begin
      #200000;
      bad++;
      $display("FAIL watchdog: simulation did not finish");
      $display("test done: total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog expired");
   end

endmodule
